// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC, lookahead ROM address, IR capture,
//            IR validity tracking and saturating fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W  = 8,
    parameter int IW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PC_clr,
    input  logic [PC_W-1:0]  PC_inc,
    input  logic             IR_ld,
    input  logic [IW-1:0]    IM_data,
    output logic [PC_W-1:0]  IM_addr,
    output logic [PC_W-1:0]  PC,
    output logic [IW-1:0]    IR,
    output logic             IR_valid,
    output logic [CNT_W-1:0] Fetch_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_EMPTY  = 1'b0,
        S_LOADED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [IW-1:0]    r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    // Lookahead address: the ROM registers it on the same edge PC updates.
    always_comb begin
        w_pc_next = PC_clr ? '0 : (r_pc + PC_inc);
        IM_addr   = Reset ? '0 : w_pc_next;
    end

    // Clear applies before the load is counted.
    always_comb begin
        w_cnt_base = PC_clr ? '0 : r_cnt;
        w_cnt_next = w_cnt_base;
        if (IR_ld && (w_cnt_base != c_CNT_MAX)) begin
            w_cnt_next = w_cnt_base + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY:  if (IR_ld) w_state_next = S_LOADED;
            S_LOADED: if (PC_clr && !IR_ld) w_state_next = S_EMPTY;
            default:  w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_cnt <= '0;
        end else begin
            r_pc  <= w_pc_next;
            r_cnt <= w_cnt_next;
            if (IR_ld) begin
                r_ir <= IM_data;
            end
        end
    end

    assign PC          = r_pc;
    assign IR          = r_ir;
    assign IR_valid    = (r_state == S_LOADED);
    assign Fetch_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Randomized and directed bench for fetch_unit against a
//            cycle-level behavioural model of the fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        PC_clr;
    logic [7:0]  PC_inc;
    logic        IR_ld;
    logic [15:0] IM_data;
    logic [7:0]  IM_addr;
    logic [7:0]  PC;
    logic [15:0] IR;
    logic        IR_valid;
    logic [15:0] Fetch_count;

    logic [15:0] mem [256];

    int n_vec;
    int n_bad;

    // Behavioural model state
    int m_pc;
    int m_ir;
    int m_valid;
    int m_cnt;

    fetch_unit #(.PC_W(8), .IW(16), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PC_clr      (PC_clr),
        .PC_inc      (PC_inc),
        .IR_ld       (IR_ld),
        .IM_data     (IM_data),
        .IM_addr     (IM_addr),
        .PC          (PC),
        .IR          (IR),
        .IR_valid    (IR_valid),
        .Fetch_count (Fetch_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Synchronous instruction ROM
    always @(posedge Clk) IM_data <= mem[IM_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("pc", {24'd0, PC}, m_pc[31:0]);
        chk("ir", {16'd0, IR}, m_ir[31:0]);
        chk("valid", {31'd0, IR_valid}, m_valid[31:0]);
        chk("count", {16'd0, Fetch_count}, m_cnt[31:0]);
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_valid = 0; m_cnt = 0;
    endtask

    // One clock cycle: drive, check lookahead address, edge, update model, check.
    task automatic step(input logic clr, input logic [7:0] inc, input logic ld);
        int exp_addr;
        @(negedge Clk);
        PC_clr = clr; PC_inc = inc; IR_ld = ld;
        #1;
        exp_addr = clr ? 0 : (m_pc + int'(inc)) % 256;
        chk("im_addr", {24'd0, IM_addr}, exp_addr[31:0]);
        @(posedge Clk);
        if (ld) begin
            m_ir    = int'(mem[m_pc]);
            m_valid = 1;
            m_cnt   = clr ? 0 : m_cnt;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (clr) begin
            m_valid = 0;
            m_cnt   = 0;
        end
        m_pc = exp_addr;
        #1;
        check_state();
    endtask

    initial begin
        logic [15:0] ir_hold;
        int r;
        n_vec = 0; n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 16) ? 16'hA000 + 16'(i) : 16'($urandom);
        end
        Reset = 1'b1; PC_clr = 1'b0; PC_inc = 8'd0; IR_ld = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_state();
        chk("reset_im_addr", {24'd0, IM_addr}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Sequential fetch
        step(1'b1, 8'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'd1, 1'b1);
            chk("seq_ir", {16'd0, IR}, 32'hA000 + k);
        end
        chk("seq_pc", {24'd0, PC}, 32'd3);
        chk("seq_count", {16'd0, Fetch_count}, 32'd3);

        // Jump with wrap
        step(1'b1, 8'd0, 1'b0);
        step(1'b0, 8'hF0, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        chk("wrap_pc", {24'd0, PC}, 32'h10);
        step(1'b0, 8'd0, 1'b1);
        chk("wrap_ir", {16'd0, IR}, {16'd0, mem[8'h10]});

        // Clear has priority over increment; IR is retained
        step(1'b1, 8'd0, 1'b1);
        step(1'b0, 8'd5, 1'b0);
        ir_hold = IR;
        step(1'b1, 8'd3, 1'b0);
        chk("clr_pc", {24'd0, PC}, 32'd0);
        chk("clr_valid", {31'd0, IR_valid}, 32'd0);
        chk("clr_count", {16'd0, Fetch_count}, 32'd0);
        chk("clr_ir", {16'd0, IR}, {16'd0, ir_hold});

        // Simultaneous clear and load at PC = 9
        step(1'b0, 8'd9, 1'b0);
        step(1'b1, 8'd0, 1'b1);
        chk("both_ir", {16'd0, IR}, {16'd0, mem[9]});
        chk("both_valid", {31'd0, IR_valid}, 32'd1);
        chk("both_count", {16'd0, Fetch_count}, 32'd1);
        chk("both_pc", {24'd0, PC}, 32'd0);

        // Asynchronous reset mid-cycle with PC = 8'h37 and IR valid
        step(1'b0, 8'h37, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check_state();
        chk("areset_im_addr", {24'd0, IM_addr}, 32'd0);
        PC_clr = 1'b0; PC_inc = 8'd0; IR_ld = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic       c;
            logic       l;
            logic [7:0] v;
            r = int'($urandom_range(0, 99));
            c = (r < 8);
            l = ($urandom_range(0, 2) != 0);
            r = int'($urandom_range(0, 9));
            v = (r < 3) ? 8'd0 : (r < 8) ? 8'd1 : 8'($urandom);
            step(c, v, l);
        end

        // Counter saturation
        step(1'b1, 8'd0, 1'b0);
        for (int n = 0; n < 65537; n++) begin
            step(1'b0, 8'($urandom), 1'b1);
        end
        chk("sat_count", {16'd0, Fetch_count}, 32'hFFFF);
        step(1'b0, 8'd1, 1'b1);
        step(1'b0, 8'd1, 1'b1);
        chk("sat_hold", {16'd0, Fetch_count}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
